// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two requesters (A and B) share a single combinational left shifter. At most
// one request is granted per cycle. The granted operand is shifted left and
// the vacated LSBs are filled with the requester's fill bit. The result lands
// in a one-entry output register that has a valid/ready handshake.
//
// Ports
//   Clock          sole clock, rising edge
//   ResetN         synchronous, active-low reset
//   AValid/BValid  requester has a shift request
//   AReady/BReady  request accepted this cycle (Valid && Ready)
//   AIn/BIn        operand, WIDTH bits
//   AShiftAmount/BShiftAmount  left-shift count, $clog2(WIDTH) bits
//   AShiftIn/BShiftIn          fill bit for the vacated LSBs
//   Out            registered shift result
//   OutSrc         source of Out: 0 = A, 1 = B
//   OutValid       Out/OutSrc hold a valid result
//   OutReady       consumer takes the result when OutValid && OutReady
//
// Configuration
//   SHIFT_ARBITER_RR_EN  defined: round-robin between A and B on contention.
//                        undefined (default): fixed priority, A always wins.
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                     Clock,
  input  logic                     ResetN,
  input  logic                     AValid,
  output logic                     AReady,
  input  logic [WIDTH-1:0]         AIn,
  input  logic [$clog2(WIDTH)-1:0] AShiftAmount,
  input  logic                     AShiftIn,
  input  logic                     BValid,
  output logic                     BReady,
  input  logic [WIDTH-1:0]         BIn,
  input  logic [$clog2(WIDTH)-1:0] BShiftAmount,
  input  logic                     BShiftIn,
  output logic [WIDTH-1:0]         Out,
  output logic                     OutSrc,
  output logic                     OutValid,
  input  logic                     OutReady
);

  localparam int SW = $clog2(WIDTH);

  // The shift-count field and the shifter slicing assume a power-of-2 width.
  generate
    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
      $fatal(1, "shift_arbiter: WIDTH must be a power of 2 (>= 2)");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             free;
  logic             grant_a;
  logic             grant_b;
  logic             prefer_b;
  logic [WIDTH-1:0] sel_in;
  logic [SW-1:0]    sel_amt;
  logic             sel_fill;
  logic [2*WIDTH-1:0] wide;
  logic [WIDTH-1:0] shift_result;

`ifdef SHIFT_ARBITER_RR_EN
  // last_b = 1 means B was granted most recently; on contention the other
  // requester wins. Reset value B makes A win the first contended grant.
  logic last_b;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      last_b <= 1'b1;
    end else if (grant_a || grant_b) begin
      last_b <= grant_b;
    end
  end

  assign prefer_b = ~last_b;
`else
  assign prefer_b = 1'b0;
`endif

  // Arbitration and next state. Readiness depends only on state, OutReady and
  // the valids; the slot is free when empty or being drained this cycle.
  // Holding ResetN low blocks every grant.
  always_comb begin
    free       = 1'b0;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state;

    free    = ResetN && ((state == IDLE) || OutReady);
    grant_b = free && BValid && (!AValid || prefer_b);
    grant_a = free && AValid && !grant_b;

    if (grant_a || grant_b) begin
      state_next = HOLD;
    end else if ((state == HOLD) && OutReady) begin
      state_next = IDLE;
    end
  end

  assign AReady = grant_a;
  assign BReady = grant_b;

  // Shared shifter: the fill bits sit below the operand, so shifting the
  // double-width word left and taking its upper half brings S fill bits in.
  always_comb begin
    sel_in       = grant_b ? BIn          : AIn;
    sel_amt      = grant_b ? BShiftAmount : AShiftAmount;
    sel_fill     = grant_b ? BShiftIn     : AShiftIn;
    wide         = {sel_in, {WIDTH{sel_fill}}} << sel_amt;
    shift_result = wide[2*WIDTH-1 -: WIDTH];
  end

  // Output register and state. A reset discards any held result without a
  // handshake; the register is only loaded on a grant.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state  <= IDLE;
      Out    <= '0;
      OutSrc <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_a || grant_b) begin
        Out    <= shift_result;
        OutSrc <= grant_b;
      end
    end
  end

  assign OutValid = (state == HOLD);

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Directed test bench for shift_arbiter (WIDTH = 32) with a cycle-level
// reference model running alongside. Inputs change 1 time unit after the
// rising edge; all outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

  localparam int WIDTH = 32;

  logic        Clock;
  logic        ResetN;
  logic        AValid, AReady, AShiftIn;
  logic [31:0] AIn;
  logic [4:0]  AShiftAmount;
  logic        BValid, BReady, BShiftIn;
  logic [31:0] BIn;
  logic [4:0]  BShiftAmount;
  logic [31:0] Out;
  logic        OutSrc, OutValid, OutReady;

  int checks = 0;
  int errors = 0;
  logic sbEnable = 1'b0;

  // Reference model state
  logic        mValid;
  logic [31:0] mOut;
  logic        mSrc;
  logic        mLastB;

  shift_arbiter #(.WIDTH(WIDTH)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .AValid(AValid), .AReady(AReady), .AIn(AIn),
    .AShiftAmount(AShiftAmount), .AShiftIn(AShiftIn),
    .BValid(BValid), .BReady(BReady), .BIn(BIn),
    .BShiftAmount(BShiftAmount), .BShiftIn(BShiftIn),
    .Out(Out), .OutSrc(OutSrc), .OutValid(OutValid), .OutReady(OutReady)
  );

  // 10-unit clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one observed value to its expected value and log a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a full input vector just after the next rising edge
  task automatic applyStimulus(input logic rstN,
                               input logic av, input logic [31:0] ain,
                               input logic [4:0] aamt, input logic afill,
                               input logic bv, input logic [31:0] bin,
                               input logic [4:0] bamt, input logic bfill,
                               input logic ordy);
    @(posedge Clock);
    #1;
    ResetN = rstN;
    AValid = av; AIn = ain; AShiftAmount = aamt; AShiftIn = afill;
    BValid = bv; BIn = bin; BShiftAmount = bamt; BShiftIn = bfill;
    OutReady = ordy;
  endtask

  // Reference shift: plain left shift, then OR in a mask of amt ones
  function automatic logic [31:0] shiftRef(input logic [31:0] in,
                                           input logic [4:0] amt,
                                           input logic fill);
    logic [31:0] r;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    r = in << amt;
    if (fill && amt != 0) r = r | (ones >> (6'd32 - {1'b0, amt}));
    return r;
  endfunction

  // Model grants: bit 1 = A granted, bit 0 = B granted
  function automatic logic [1:0] modelGrant();
    logic slot;
    logic preferB;
    slot = ResetN && (!mValid || OutReady);
`ifdef SHIFT_ARBITER_RR_EN
    preferB = !mLastB;
`else
    preferB = 1'b0;
`endif
    if (!slot) return 2'b00;
    if (AValid && BValid) return preferB ? 2'b01 : 2'b10;
    if (AValid) return 2'b10;
    if (BValid) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model update on the rising edge
  always @(posedge Clock) begin
    logic [1:0] g;
    g = modelGrant();
    if (!ResetN) begin
      mValid <= 1'b0;
      mOut   <= 32'h0;
      mSrc   <= 1'b0;
      mLastB <= 1'b1;
    end else if (g != 2'b00) begin
      mValid <= 1'b1;
      mOut   <= g[0] ? shiftRef(BIn, BShiftAmount, BShiftIn)
                     : shiftRef(AIn, AShiftAmount, AShiftIn);
      mSrc   <= g[0];
      mLastB <= g[0];
    end else if (mValid && OutReady) begin
      mValid <= 1'b0;
    end
  end

  // Scoreboard on every falling edge once reset has been applied
  always @(negedge Clock) begin
    logic [1:0] g;
    if (sbEnable) begin
      g = modelGrant();
      checkOutput("sb_out",      Out,      mOut);
      checkOutput("sb_src",      {31'b0, OutSrc},   {31'b0, mSrc});
      checkOutput("sb_valid",    {31'b0, OutValid}, {31'b0, mValid});
      checkOutput("sb_a_ready",  {31'b0, AReady},   {31'b0, g[1]});
      checkOutput("sb_b_ready",  {31'b0, BReady},   {31'b0, g[0]});
      checkOutput("sb_one_hot",  {31'b0, AReady && BReady}, 32'h0);
    end
  end

  // Directed sequence
  initial begin
    logic expSrc [4];
    ResetN = 1'b0;
    AValid = 1'b1; AIn = 32'h0; AShiftAmount = 5'd0; AShiftIn = 1'b0;
    BValid = 1'b1; BIn = 32'h0; BShiftAmount = 5'd0; BShiftIn = 1'b0;
    OutReady = 1'b0;

`ifdef SHIFT_ARBITER_RR_EN
    expSrc[0] = 1'b0; expSrc[1] = 1'b1; expSrc[2] = 1'b0; expSrc[3] = 1'b1;
`else
    expSrc[0] = 1'b0; expSrc[1] = 1'b0; expSrc[2] = 1'b0; expSrc[3] = 1'b0;
`endif

    // Reset state, with both requesters pushing during reset
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    sbEnable = 1'b1;
    checkOutput("rst_out",     Out, 32'h0);
    checkOutput("rst_valid",   {31'b0, OutValid}, 32'h0);
    checkOutput("rst_src",     {31'b0, OutSrc},   32'h0);
    checkOutput("rst_a_ready", {31'b0, AReady},   32'h0);
    checkOutput("rst_b_ready", {31'b0, BReady},   32'h0);

    // A: 0xFF << 4, fill 0
    applyStimulus(1, 1, 32'h0000_00FF, 5'd4, 0, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    checkOutput("a1_ready", {31'b0, AReady}, 32'h1);
    applyStimulus(1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    checkOutput("a1_out",   Out, 32'h0000_0FF0);
    checkOutput("a1_src",   {31'b0, OutSrc},   32'h0);
    checkOutput("a1_valid", {31'b0, OutValid}, 32'h1);

    // B: 0x80000001 << 31 fill 1, then shift 0
    applyStimulus(1, 0, 32'h0, 5'd0, 0, 1, 32'h8000_0001, 5'd31, 1, 1);
    @(negedge Clock);
    checkOutput("drain_valid", {31'b0, OutValid}, 32'h0);
    checkOutput("b1_ready",    {31'b0, BReady},   32'h1);
    applyStimulus(1, 0, 32'h0, 5'd0, 0, 1, 32'h8000_0001, 5'd0, 1, 1);
    @(negedge Clock);
    checkOutput("b31_out", Out, 32'hFFFF_FFFF);
    checkOutput("b31_src", {31'b0, OutSrc}, 32'h1);
    applyStimulus(1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    checkOutput("b0_out", Out, 32'h8000_0001);
    checkOutput("b0_src", {31'b0, OutSrc}, 32'h1);

    // Contention: A gives 1<<1 = 0x2, B gives (3<<2)|0x3 = 0xF
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 32'h1, 5'd1, 0, 1, 32'h3, 5'd2, 1, 1);
      @(negedge Clock);
      checkOutput("rr_a_ready", {31'b0, AReady}, {31'b0, !expSrc[i]});
      checkOutput("rr_b_ready", {31'b0, BReady}, {31'b0, expSrc[i]});
      if (i > 0) begin
        checkOutput("rr_src", {31'b0, OutSrc}, {31'b0, expSrc[i-1]});
        checkOutput("rr_out", Out, expSrc[i-1] ? 32'hF : 32'h2);
      end
    end

    // A: 0x12 << 8 = 0x1200; the last contended result drains at the same time
    applyStimulus(1, 1, 32'h12, 5'd8, 0, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    checkOutput("rr_src_last", {31'b0, OutSrc}, {31'b0, expSrc[3]});
    checkOutput("hold_a_ready0", {31'b0, AReady}, 32'h1);

    // Stall 5 cycles with A requesting (0x34 << 4 fill 1 = 0x34F)
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 32'h34, 5'd4, 1, 0, 32'h0, 5'd0, 0, 0);
      @(negedge Clock);
      checkOutput("stall_out",     Out, 32'h0000_1200);
      checkOutput("stall_valid",   {31'b0, OutValid}, 32'h1);
      checkOutput("stall_a_ready", {31'b0, AReady},   32'h0);
    end
    applyStimulus(1, 1, 32'h34, 5'd4, 1, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    checkOutput("unstall_a_ready", {31'b0, AReady}, 32'h1);
    checkOutput("unstall_out_old", Out, 32'h0000_1200);
    applyStimulus(1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 0);
    @(negedge Clock);
    checkOutput("unstall_out", Out, 32'h0000_034F);
    checkOutput("unstall_src", {31'b0, OutSrc}, 32'h0);

    // Reset while holding a result
    applyStimulus(0, 1, 32'h0, 5'd0, 0, 1, 32'h0, 5'd0, 0, 0);
    @(negedge Clock);
    checkOutput("mid_rst_a_ready", {31'b0, AReady}, 32'h0);
    checkOutput("mid_rst_b_ready", {31'b0, BReady}, 32'h0);
    applyStimulus(1, 1, 32'h5, 5'd0, 0, 1, 32'h7, 5'd3, 0, 1);
    @(negedge Clock);
    checkOutput("post_rst_valid",   {31'b0, OutValid}, 32'h0);
    checkOutput("post_rst_out",     Out, 32'h0);
    checkOutput("post_rst_a_ready", {31'b0, AReady}, 32'h1);
    checkOutput("post_rst_b_ready", {31'b0, BReady}, 32'h0);
    applyStimulus(1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    checkOutput("post_rst_res", Out, 32'h5);
    checkOutput("post_rst_src", {31'b0, OutSrc}, 32'h0);

    applyStimulus(1, 0, 32'h0, 5'd0, 0, 0, 32'h0, 5'd0, 0, 1);
    @(negedge Clock);
    sbEnable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
